// File: rtl/crc_seq_pkg.sv
// crc_seq_pkg: shared types, widths and helpers for the table-driven CRC sequencer.
//
// Contents:
//   CRC_W / BYTE_W / TAB_AW / BIDX_W   datapath, byte, table-address and byte-index widths
//   crc_seq_state_e                    sequencer FSM state (StIdle / StRun / StDone)
//   sel_byte()                         pick byte <idx> of a word, byte 0 being the MSB byte
package crc_seq_pkg;

  localparam int unsigned CRC_W  = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned TAB_AW = 8;
  localparam int unsigned BIDX_W = 2;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } crc_seq_state_e;

  // Words are walked MSB byte first, so index 0 selects word[31:24].
  function automatic logic [BYTE_W-1:0] sel_byte(input logic [CRC_W-1:0]  word,
                                                 input logic [BIDX_W-1:0] idx);
    logic [CRC_W-1:0] shifted;
    shifted = word << (BYTE_W * idx);
    return shifted[CRC_W-1 -: BYTE_W];
  endfunction

endpackage

// File: rtl/crc_seq_byte_step.sv
// crc_seq_byte_step: one byte of a table-driven CRC update (purely combinational).
//
// The table ROM lives outside; this block forms its address from the running CRC and
// the current byte, then folds the returned table word into the shifted CRC.
//
// Ports:
//   crc_i        running CRC value (crc_q of the sequencer)
//   byte_i       byte being consumed this cycle
//   tab_addr_o   table address = crc_i[31:24] ^ byte_i
//   tab_rdata_i  table word read at tab_addr_o
//   crc_next_o   updated CRC = {crc_i[23:0], 8'h00} ^ tab_rdata_i
module crc_seq_byte_step
  import crc_seq_pkg::*;
(
  input  logic [CRC_W-1:0]  crc_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [TAB_AW-1:0] tab_addr_o,
  input  logic [CRC_W-1:0]  tab_rdata_i,
  output logic [CRC_W-1:0]  crc_next_o
);

  assign tab_addr_o = crc_i[CRC_W-1 -: BYTE_W] ^ byte_i;

  assign crc_next_o = {crc_i[CRC_W-BYTE_W-1:0], {BYTE_W{1'b0}}} ^ tab_rdata_i;

endmodule

// File: rtl/crc_lut_seq.sv
// crc_lut_seq: sequencer driving an external 256x32 CRC lookup-table ROM to compute a
// 32-bit table-driven CRC over a stream of 32-bit words, one byte per clock.
//
// Build option: define CRC_SEQ_FINXOR_EN to XOR the frame result with XOROUT before it
// is presented on out_crc; without it out_crc is the raw CRC register value.
//
// Parameters:
//   INIT    CRC register value at frame start (and after reset)
//   XOROUT  final XOR value (only used with CRC_SEQ_FINXOR_EN)
//
// Ports:
//   clk, rst    clock; asynchronous active-high reset
//   in_valid    input word valid
//   in_ready    sequencer can take a word (held low while rst is asserted)
//   in_data     word; byte 0 = in_data[31:24]
//   in_last     word is the last of the frame
//   in_nbytes   valid bytes in the last word from the MSB end, 0 means 4
//   out_valid   out_crc valid
//   out_ready   consumer takes the CRC
//   out_crc     frame CRC, stable while out_valid && !out_ready
//   tab_addr    table address (combinational from crc_q and the current byte)
//   tab_rdata   table data, combinational ROM read of tab_addr
module crc_lut_seq
  import crc_seq_pkg::*;
#(
  parameter logic [CRC_W-1:0] INIT   = 32'hFFFF_FFFF,
  parameter logic [CRC_W-1:0] XOROUT = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CRC_W-1:0]  in_data,
  input  logic              in_last,
  input  logic [1:0]        in_nbytes,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CRC_W-1:0]  out_crc,
  output logic [TAB_AW-1:0] tab_addr,
  input  logic [CRC_W-1:0]  tab_rdata
);

  crc_seq_state_e    state_q, state_d;
  logic [CRC_W-1:0]  word_q, word_d;
  logic [BIDX_W-1:0] bcnt_q, bcnt_d;
  logic [BIDX_W-1:0] nlast_q, nlast_d;
  logic              last_q, last_d;
  logic [CRC_W-1:0]  crc_q, crc_d;
  logic [CRC_W-1:0]  out_crc_q, out_crc_d;

  logic [BYTE_W-1:0] cur_byte;
  logic [CRC_W-1:0]  crc_next;
  logic [CRC_W-1:0]  fin_crc;
  logic              at_last_byte;
  logic              accept;
  logic [BIDX_W-1:0] in_nlast;

  // ---------------------------------------------------------------------------
  // Byte step datapath
  // ---------------------------------------------------------------------------

  assign cur_byte = sel_byte(word_q, bcnt_q);

  crc_seq_byte_step u_byte_step (
    .crc_i       (crc_q),
    .byte_i      (cur_byte),
    .tab_addr_o  (tab_addr),
    .tab_rdata_i (tab_rdata),
    .crc_next_o  (crc_next)
  );

`ifdef CRC_SEQ_FINXOR_EN
  assign fin_crc = crc_next ^ XOROUT;
`else
  assign fin_crc = crc_next;
  logic unused_xorout;
  assign unused_xorout = ^XOROUT;
`endif

  assign at_last_byte = (bcnt_q == nlast_q);
  assign accept       = in_valid & in_ready;

  // Index of the final byte of the incoming word; nbytes==0 wraps to 3 (four bytes).
  assign in_nlast = in_last ? (in_nbytes - 2'd1) : 2'd3;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (at_last_byte) begin
          if (last_q) begin
            state_d = StDone;
          end else if (!accept) begin
            state_d = StIdle;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle:  in_ready = 1'b1;
      // Taking the next word on the last-byte cycle keeps full words bubble-free.
      StRun:   in_ready = at_last_byte & ~last_q;
      StDone:  out_valid = 1'b1;
      default: in_ready = 1'b0;
    endcase
    if (rst) begin
      in_ready = 1'b0;
    end
  end

  assign out_crc = out_crc_q;

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------

  always_comb begin
    word_d    = word_q;
    bcnt_d    = bcnt_q;
    nlast_d   = nlast_q;
    last_d    = last_q;
    crc_d     = crc_q;
    out_crc_d = out_crc_q;

    unique case (state_q)
      StIdle: begin
        // crc_q is left alone so a mid-frame pause continues the running CRC.
        if (accept) begin
          word_d  = in_data;
          last_d  = in_last;
          nlast_d = in_nlast;
          bcnt_d  = '0;
        end
      end
      StRun: begin
        crc_d  = crc_next;
        bcnt_d = bcnt_q + 2'd1;
        if (at_last_byte) begin
          if (last_q) begin
            out_crc_d = fin_crc;
          end else if (accept) begin
            word_d  = in_data;
            last_d  = in_last;
            nlast_d = in_nlast;
            bcnt_d  = '0;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          crc_d = INIT;
        end
      end
      default: begin
        crc_d = INIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q    <= '0;
      bcnt_q    <= '0;
      nlast_q   <= '0;
      last_q    <= 1'b0;
      crc_q     <= INIT;
      out_crc_q <= '0;
    end else begin
      word_q    <= word_d;
      bcnt_q    <= bcnt_d;
      nlast_q   <= nlast_d;
      last_q    <= last_d;
      crc_q     <= crc_d;
      out_crc_q <= out_crc_d;
    end
  end

endmodule

// File: tb/tb_crc_lut_seq.sv
// tb_crc_lut_seq: self-checking bench for crc_lut_seq.
//
// The table ROM is modelled here as an array with random contents, except for the three
// entries the directed frames rely on. Expected CRCs come from folding the frame's byte
// list through the byte update rule; the final XOR follows CRC_SEQ_FINXOR_EN.
module tb_crc_lut_seq;

  localparam logic [31:0] INIT_V   = 32'h0000_0000;
  localparam logic [31:0] XOROUT_V = 32'hFFFF_FFFF;
`ifdef CRC_SEQ_FINXOR_EN
  localparam logic [31:0] FIN_X = XOROUT_V;
`else
  localparam logic [31:0] FIN_X = 32'h0000_0000;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [1:0]  in_nbytes;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_crc;
  logic [7:0]  tab_addr;
  logic [31:0] tab_rdata;

  logic [31:0] rom [256];
  assign tab_rdata = rom[tab_addr];

  crc_lut_seq #(
    .INIT   (INIT_V),
    .XOROUT (XOROUT_V)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_nbytes (in_nbytes),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_crc   (out_crc),
    .tab_addr  (tab_addr),
    .tab_rdata (tab_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Current frame: words plus byte count of the final word.
  logic [31:0] fw[$];
  logic [1:0]  fnb;
  logic [7:0]  fbytes[$];
  logic [7:0]  exp_addr[$];
  logic [31:0] last_out;

  // Flatten the frame to its byte list and fold it through the update rule.
  task automatic build_model(output logic [31:0] crc);
    logic [31:0] c;
    logic [7:0]  b;
    logic [7:0]  a;
    int          k;
    fbytes.delete();
    exp_addr.delete();
    c = INIT_V;
    for (int i = 0; i < fw.size(); i++) begin
      k = (i == fw.size() - 1) ? ((fnb == 2'd0) ? 4 : int'(fnb)) : 4;
      for (int j = 0; j < k; j++) begin
        b = 8'(fw[i] >> (24 - 8 * j));
        fbytes.push_back(b);
      end
    end
    foreach (fbytes[i]) begin
      a = c[31:24] ^ fbytes[i];
      exp_addr.push_back(a);
      c = (c << 8) ^ rom[a];
    end
    crc = c ^ FIN_X;
  endtask

  task automatic run_frame(input int stall, input bit bubbles);
    logic [31:0] exp;
    int          k;
    int          wait_n;
    int          lat;
    int          gap;
    int          base;
    build_model(exp);
    k = (fnb == 2'd0) ? 4 : int'(fnb);
    for (int i = 0; i < fw.size(); i++) begin
      gap = (bubbles && i > 0) ? int'($urandom_range(0, 5)) : 0;
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        in_data  = $urandom;
        @(negedge clk);
      end
      in_valid  = 1'b1;
      in_data   = fw[i];
      in_last   = (i == fw.size() - 1);
      in_nbytes = in_last ? fnb : 2'($urandom);
      wait_n    = 0;
      while (!in_ready && wait_n < 50) begin
        @(negedge clk);
        wait_n++;
      end
      if (i == 0) check_eq("first_word_ready_wait", 32'(wait_n), 32'd0);
      else if (gap == 0) check_eq("b2b_ready_wait", 32'(wait_n), 32'd3);
      else if (wait_n >= 50) check_eq("in_ready_timeout", 32'(wait_n), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = $urandom;

    base = fbytes.size() - k;
    lat  = 0;
    while (!out_valid && lat < 20) begin
      if (lat < k) check_eq("tab_addr", 32'(tab_addr), 32'(exp_addr[base+lat]));
      @(negedge clk);
      lat++;
    end
    check_eq("latency", 32'(lat), 32'(k));
    check_eq("out_crc", out_crc, exp);
    last_out = out_crc;

    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check_eq("stall_out_valid", 32'(out_valid), 32'd1);
      check_eq("stall_out_crc", out_crc, exp);
      check_eq("stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("post_hs_out_valid", 32'(out_valid), 32'd0);
    check_eq("post_hs_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    rom[8'h01] = 32'h218e_0c78;
    rom[8'h80] = 32'h8b17_e770;
    rom[8'h21] = 32'h034b_f5a4;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_nbytes = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_crc", out_crc, 32'd0);
    check_eq("rst_tab_addr", 32'(tab_addr), 32'(INIT_V[31:24]));
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_in_ready", 32'(in_ready), 32'd1);

    // Directed single- and two-byte frames.
    fw = '{32'h0100_0000};
    fnb = 2'd1;
    run_frame(0, 1'b0);
    check_eq("single_01", last_out, 32'h218e_0c78 ^ FIN_X);

    fw = '{32'h8000_0000};
    fnb = 2'd1;
    run_frame(1, 1'b0);
    check_eq("single_80", last_out, 32'h8b17_e770 ^ FIN_X);

    fw = '{32'h0100_0000};
    fnb = 2'd2;
    run_frame(0, 1'b0);
    check_eq("two_byte", last_out, 32'h8d47_8da4 ^ FIN_X);

    // Three back-to-back full words, consumer stalls for 5 cycles.
    fw = '{$urandom, $urandom, $urandom};
    fnb = 2'd0;
    run_frame(5, 1'b0);

    // Reset while byte 2 of a full last word is in flight.
    in_valid  = 1'b1;
    in_data   = $urandom;
    in_last   = 1'b1;
    in_nbytes = 2'd0;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midrst_in_ready", 32'(in_ready), 32'd0);
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_out_crc", out_crc, 32'd0);
    check_eq("midrst_tab_addr", 32'(tab_addr), 32'(INIT_V[31:24]));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("midrst_no_output", 32'(out_valid), 32'd0);
    end
    fw = '{32'h0100_0000};
    fnb = 2'd1;
    run_frame(0, 1'b0);
    check_eq("after_rst_single_01", last_out, 32'h218e_0c78 ^ FIN_X);

    // Random frames with random bubbles, byte counts and consumer stalls.
    for (int f = 0; f < 40; f++) begin
      int nw;
      nw = int'($urandom_range(1, 5));
      fw.delete();
      for (int w = 0; w < nw; w++) fw.push_back($urandom);
      fnb = 2'($urandom);
      run_frame(int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
